// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: one single-port RAM shared by VGA scan-out, the Core,
// encoder-driven pixel plotting and a clear-screen engine (VGA > clear > round-robin Core/plot).
module fb_port_arbiter #(
    parameter int AW    = 15,
    parameter int DW    = 16,
    parameter int DEPTH = 19200
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic          vga_rvalid,
    output logic [DW-1:0] vga_rdata,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          plot_req,
    input  logic [AW-1:0] plot_addr,
    input  logic [DW-1:0] plot_wdata,
    output logic          plot_gnt,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          clr_busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {IDLE, CLEAR} clrState_t;

    clrState_t     state;
    clrState_t     stateNext;
    logic [AW-1:0] clrAddr;
    logic [DW-1:0] clrColor;
    logic          clrWrite;
    logic          clrLast;
    logic          lastCore;
    logic          vgaRd_p1;
    logic          coreRd_p1;

    assign clrLast = (clrAddr == AW'(DEPTH - 1));

    always_comb begin
        vga_gnt   = 1'b0;
        core_gnt  = 1'b0;
        plot_gnt  = 1'b0;
        clrWrite  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stateNext = state;
        if (rstN) begin
            if (vga_req) begin
                vga_gnt  = 1'b1;
                mem_en   = 1'b1;
                mem_addr = vga_addr;
            end else if (state == CLEAR) begin
                clrWrite  = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clrAddr;
                mem_wdata = clrColor;
            // on a tie the requester not served last wins
            end else if (core_req && (!plot_req || !lastCore)) begin
                core_gnt  = 1'b1;
                mem_en    = 1'b1;
                mem_we    = core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
            end else if (plot_req) begin
                plot_gnt  = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = plot_addr;
                mem_wdata = plot_wdata;
            end
        end
        case (state)
            IDLE:    if (clr_start) stateNext = CLEAR;
            CLEAR:   if (clrWrite && clrLast) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) state <= IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            clrAddr   <= '0;
            clrColor  <= '0;
            lastCore  <= 1'b1;
            vgaRd_p1  <= 1'b0;
            coreRd_p1 <= 1'b0;
        end else begin
            if (state == IDLE && clr_start) begin
                clrColor <= clr_color;
                clrAddr  <= '0;
            end else if (clrWrite) begin
                clrAddr <= clrLast ? '0 : clrAddr + AW'(1);
            end
            if (core_gnt)      lastCore <= 1'b1;
            else if (plot_gnt) lastCore <= 1'b0;
            vgaRd_p1  <= vga_gnt;
            coreRd_p1 <= core_gnt & ~core_we;
        end
    end

    // read data returns one cycle after the grant; suppressed if reset hits the data cycle
    assign vga_rvalid  = vgaRd_p1 & rstN;
    assign core_rvalid = coreRd_p1 & rstN;
    assign vga_rdata   = mem_rdata;
    assign core_rdata  = mem_rdata;
    assign clr_busy    = (state == CLEAR);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural single-port RAM behind it.
module tb_fb_port_arbiter;

    localparam int AW    = 15;
    localparam int DW    = 16;
    localparam int DEPTH = 19200;

    logic          clk = 1'b0;
    logic          rstN;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_gnt;
    logic          vga_rvalid;
    logic [DW-1:0] vga_rdata;
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          plot_req;
    logic [AW-1:0] plot_addr;
    logic [DW-1:0] plot_wdata;
    logic          plot_gnt;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          clr_busy;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    fb_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstN(rstN),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .plot_req(plot_req), .plot_addr(plot_addr), .plot_wdata(plot_wdata),
        .plot_gnt(plot_gnt),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n, writes, busyCnt, vgaCnt, seqErr, coreEarly, coreCnt;
        logic done;
        logic pe [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

        // reset with every requester active
        rstN = 1'b0; vga_req = 1'b1; vga_addr = '0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 15'h0100; core_wdata = 16'h1234;
        plot_req = 1'b1; plot_addr = 15'h0010; plot_wdata = 16'h00A5;
        clr_start = 1'b0; clr_color = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_vga_gnt", vga_gnt, 0);
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_plot_gnt", plot_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_vga_rvalid", vga_rvalid, 0);
        chk("rst_core_rvalid", core_rvalid, 0);
        chk("rst_clr_busy", clr_busy, 0);

        @(negedge clk); rstN = 1'b1; #1;
        chk("rel_vga_gnt", vga_gnt, 1);
        chk("rel_core_gnt", core_gnt, 0);
        chk("rel_plot_gnt", plot_gnt, 0);
        chk("rel_mem_we", mem_we, 0);

        @(negedge clk); vga_req = 1'b0; #1;
        chk("rel_vga_rvalid", vga_rvalid, 1);
        chk("tie1_plot_gnt", plot_gnt, 1);
        chk("tie1_core_gnt", core_gnt, 0);
        chk("tie1_mem_addr", mem_addr, 15'h0010);
        chk("tie1_mem_wdata", mem_wdata, 16'h00A5);

        @(negedge clk); plot_req = 1'b0; #1;
        chk("cw_core_gnt", core_gnt, 1);
        chk("cw_mem_we", mem_we, 1);
        chk("cw_mem_addr", mem_addr, 15'h0100);

        @(negedge clk); core_req = 1'b0; #1;
        chk("cw_no_rvalid", core_rvalid, 0);
        chk("idle_mem_en", mem_en, 0);

        // VGA read with a colliding Core write
        @(negedge clk);
        vga_req = 1'b1; vga_addr = 15'h0010;
        core_req = 1'b1; core_we = 1'b1; core_addr = 15'h0300; core_wdata = 16'h7777;
        #1;
        chk("vr_vga_gnt", vga_gnt, 1);
        chk("vr_core_wait", core_gnt, 0);
        chk("vr_mem_addr", mem_addr, 15'h0010);
        @(negedge clk); vga_req = 1'b0; #1;
        chk("vr_rvalid", vga_rvalid, 1);
        chk("vr_rdata", vga_rdata, 16'h00A5);
        chk("vr_core_gnt", core_gnt, 1);
        chk("vr_core_addr", mem_addr, 15'h0300);
        @(negedge clk); core_req = 1'b0; #1;
        chk("vr_rvalid_drop", vga_rvalid, 0);

        // Core read and plot write held together: plot, core, plot, core
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            core_req = 1'b1; core_we = 1'b0; core_addr = 15'h0100;
            plot_req = 1'b1; plot_addr = 15'h0200; plot_wdata = 16'h00E0;
            #1;
            chk("rr_plot_gnt", plot_gnt, pe[k]);
            chk("rr_core_gnt", core_gnt, !pe[k]);
            chk("rr_core_rvalid", core_rvalid, (k == 2));
            chk("rr_vga_rvalid", vga_rvalid, 0);
        end
        @(negedge clk); core_req = 1'b0; plot_req = 1'b0; #1;
        chk("rr_last_rvalid", core_rvalid, 1);
        chk("rr_last_rdata", core_rdata, 16'h1234);
        @(negedge clk); vga_req = 1'b1; vga_addr = 15'h0200; #1;
        @(negedge clk); vga_req = 1'b0; #1;
        chk("plot_readback", vga_rdata, 16'h00E0);
        chk("plot_rb_rvalid", vga_rvalid, 1);

        // full clear with VGA every 4th cycle and the Core waiting
        @(negedge clk); clr_start = 1'b1; clr_color = 16'h001C; vga_addr = '0; #1;
        chk("clr_busy_start", clr_busy, 0);
        n = 0; writes = 0; busyCnt = 0; vgaCnt = 0; seqErr = 0; coreEarly = 0; done = 1'b0;
        while (!done && n < 30000) begin
            @(negedge clk);
            clr_start = 1'b0;
            core_req = 1'b1; core_we = 1'b1; core_addr = 15'h0400; core_wdata = 16'h4444;
            vga_req = (n % 4 == 1);
            #1;
            if (clr_busy) begin
                busyCnt++;
                if (vga_gnt) vgaCnt++;
                if (core_gnt || plot_gnt) coreEarly++;
                if (mem_en && mem_we) begin
                    if (mem_addr !== AW'(writes) || mem_wdata !== 16'h001C) seqErr++;
                    writes++;
                end
            end else begin
                done = 1'b1;
                chk("clr_exit_core_gnt", core_gnt, 1);
            end
            n++;
        end
        chk("clr_done", done, 1);
        chk("clr_writes", writes, DEPTH);
        chk("clr_seq_err", seqErr, 0);
        chk("clr_vga_cnt", vgaCnt, 6400);
        chk("clr_busy_cycles", busyCnt, 25600);
        chk("clr_core_held", coreEarly, 0);
        @(negedge clk); core_req = 1'b0; vga_req = 1'b0; #1;
        chk("clr_ram_first", ram[0], 16'h001C);
        chk("clr_ram_last", ram[DEPTH-1], 16'h001C);
        chk("clr_core_wrote", ram[15'h0400], 16'h4444);

        // reset while the engine is about to write word 500
        @(negedge clk); clr_start = 1'b1; clr_color = 16'h00F0; #1;
        repeat (500) begin
            @(negedge clk); clr_start = 1'b0;
        end
        @(negedge clk); rstN = 1'b0; #1;
        chk("abort_mem_en", mem_en, 0);
        @(negedge clk); rstN = 1'b1; #1;
        chk("abort_clr_busy", clr_busy, 0);
        chk("abort_mem_en2", mem_en, 0);
        chk("abort_ram0", ram[0], 16'h00F0);
        chk("abort_ram499", ram[499], 16'h00F0);
        chk("abort_ram500", ram[500], 16'h001C);
        chk("abort_ram_last", ram[DEPTH-1], 16'h001C);
        chk("abort_ram1024", ram[15'h0400], 16'h4444);

        // restart at 0; a second start and a dropped Core request are ignored
        @(negedge clk); clr_start = 1'b1; clr_color = 16'h0033; #1;
        @(negedge clk); clr_start = 1'b0; #1;
        chk("restart_busy", clr_busy, 1);
        chk("restart_we", mem_we, 1);
        chk("restart_addr", mem_addr, 15'h0000);
        chk("restart_wdata", mem_wdata, 16'h0033);
        writes = 1; coreCnt = 0;
        @(negedge clk);
        clr_start = 1'b1; clr_color = 16'h0099;
        core_req = 1'b1; core_we = 1'b1; core_addr = 15'h0500; core_wdata = 16'h5555;
        #1;
        chk("ign_addr1", mem_addr, 15'h0001);
        chk("ign_core_gnt", core_gnt, 0);
        writes++;
        @(negedge clk); clr_start = 1'b0; #1;
        chk("ign_addr2", mem_addr, 15'h0002);
        chk("ign_wdata", mem_wdata, 16'h0033);
        if (core_gnt) coreCnt++;
        writes++;
        n = 0; done = 1'b0;
        while (!done && n < 25000) begin
            @(negedge clk); core_req = 1'b0; #1;
            if (clr_busy) begin
                if (mem_en && mem_we) writes++;
            end else begin
                done = 1'b1;
            end
            if (core_gnt) coreCnt++;
            n++;
        end
        repeat (3) begin
            @(negedge clk); #1;
            if (core_gnt) coreCnt++;
        end
        chk("re_done", done, 1);
        chk("re_writes", writes, DEPTH);
        chk("re_no_restart", clr_busy, 0);
        chk("re_no_core", coreCnt, 0);
        chk("re_ram500", ram[15'h0500], 16'h0033);
        chk("re_ram_last", ram[DEPTH-1], 16'h0033);
        chk("re_ram1024", ram[15'h0400], 16'h0033);

        // reset landing on the data cycle of a read
        @(negedge clk); vga_req = 1'b1; vga_addr = 15'h0010; #1;
        chk("rd_rst_gnt", vga_gnt, 1);
        @(negedge clk); vga_req = 1'b0; rstN = 1'b0; #1;
        chk("rd_rst_rvalid", vga_rvalid, 0);
        @(negedge clk); rstN = 1'b1; #1;
        chk("rd_rst_rvalid2", vga_rvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
